// File: rtl/word32_axis_tx.sv
// Packer-to-DMA bridge: 32-bit word stream into an AXI4-Stream master through a
// first-word-fall-through FIFO. Optional status counters: WORD32_AXIS_TX_STATUS_CNT_EN.
module word32_axis_tx #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [31:0]   in_data,
  input  logic          in_last,
  output logic [31:0]   m_axis_tdata,
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready,
  output logic          m_axis_tlast,
  output logic [3:0]    m_axis_tkeep,
  output logic [AW:0]   fill_level,
  output logic          ovf,
  input  logic          ovf_clr,
  output logic [15:0]   pkt_cnt,
  output logic [15:0]   drop_cnt
);

  typedef enum logic {IDLE, BUSY} pkt_state_t;

  logic [32:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          wr_en;
  logic          rd_en;
  logic          drop;
  pkt_state_t    state_q;
  pkt_state_t    state_d;

  // Fullness comes from the registered level, so a same-cycle read cannot rescue a write.
  assign full  = (fill_level == (AW + 1)'(DEPTH));
  assign wr_en = in_valid && !full;
  assign drop  = in_valid && full;
  assign rd_en = m_axis_tvalid && m_axis_tready;

  assign m_axis_tvalid = (fill_level != '0);
  assign m_axis_tdata  = mem[rd_ptr][31:0];
  assign m_axis_tlast  = mem[rd_ptr][32];
  assign m_axis_tkeep  = 4'hF;

  // NOTE: storage has no reset; tvalid masks stale entries, and a reset would block RAM inference.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {in_last, in_data};
  end

  // NOTE: all state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   fill_level <= fill_level + 1'b1;
        2'b01:   fill_level <= fill_level - 1'b1;
        default: fill_level <= fill_level;
      endcase
    end
  end

  // Setting wins over a simultaneous clear so no drop event is ever lost.
  always_ff @(posedge clk) begin
    if (rst)          ovf <= 1'b0;
    else if (drop)    ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

  // Packet tracker: observational only, it gates nothing.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: default assigned first so every path drives state_d and no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (rd_en) begin
      case (state_q)
        IDLE:    state_d = m_axis_tlast ? IDLE : BUSY;
        BUSY:    state_d = m_axis_tlast ? IDLE : BUSY;
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef WORD32_AXIS_TX_STATUS_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (rd_en && m_axis_tlast && pkt_cnt != 16'hFFFF) pkt_cnt  <= pkt_cnt + 1'b1;
      if (drop && drop_cnt != 16'hFFFF)                 drop_cnt <= drop_cnt + 1'b1;
    end
  end
`else
  assign pkt_cnt  = '0;
  assign drop_cnt = '0;
`endif

endmodule

// File: doc/word32_axis_tx.md
# word32_axis_tx

Consumes the 32-bit word stream produced by the 8-to-32 packer (`valid`/`data`/`last`, no backpressure) and presents it as an AXI4-Stream master toward the PS DMA. A synchronous FIFO absorbs DMA stalls, since the upstream source cannot be throttled. Overflow drops words and is reported through sticky status. The block sits between the packer and the AXI DMA S2MM slave port in the PL datapath.

## Interface
- `DEPTH`, 16 — FIFO depth in 32-bit words; power of two, 4..1024
- `AW`, 4 — address width, equal to log2(`DEPTH`)
- `clk` in 1 — single clock for all logic
- `rst` in 1 — synchronous, active-high reset
- `in_valid` in 1 — upstream word strobe, one word per asserted cycle
- `in_data` in 32 — upstream word
- `in_last` in 1 — qualifies `in_data` as the final word of a packet
- `m_axis_tdata` out 32 — stream data
- `m_axis_tvalid` out 1 — stream valid
- `m_axis_tready` in 1 — stream ready from the DMA
- `m_axis_tlast` out 1 — end of packet
- `m_axis_tkeep` out 4 — constant 4'hF
- `fill_level` out AW+1 — current FIFO occupancy, 0..`DEPTH`
- `ovf` out 1 — sticky overflow flag
- `ovf_clr` in 1 — single-cycle clear for `ovf`
- `pkt_cnt` out 16 — packets sent, counted on each tlast handshake (`STATUS_CNT_EN` only)
- `drop_cnt` out 16 — words dropped (`STATUS_CNT_EN` only)

## Operation
- FIFO entry is 33 bits: {last, data}. Write pointer, read pointer and `fill_level` are registered.
- **Write:** occurs when `in_valid && fill_level != DEPTH`. Fullness is evaluated before any same-cycle read, so a write arriving on a full cycle is dropped even if a read happens in that cycle.
- **Drop:** occurs when `in_valid && fill_level == DEPTH`.
  - The word is discarded, including its `last` bit.
  - `ovf` sets on the next edge.
  - `drop_cnt` increments.
- **Read:** a handshake is `m_axis_tvalid && m_axis_tready`. It advances the read pointer.
- `m_axis_tvalid` = (`fill_level != 0`). `m_axis_tdata` and `m_axis_tlast` always reflect the head entry.
- `fill_level` next value is `+1` on write-only, `-1` on read-only, and unchanged when both or neither occur.
- Pointers are AW bits wide and wrap naturally from `DEPTH-1` to 0.
- **Output packet tracker FSM:**
  - IDLE → BUSY on a handshake with tlast=0.
  - BUSY → IDLE on a handshake with tlast=1.
  - IDLE stays IDLE on a handshake with tlast=1 (single-word packet).
  - State is internal only. It gates nothing.
- `ovf`:
  - Set has priority over `ovf_clr` in the same cycle.
  - Otherwise `ovf_clr` clears it.
- AXI rule: once `m_axis_tvalid` is asserted, it and the head data hold until the handshake. This is guaranteed because nothing removes the head except a read.

## Timing
- **Reset values** (while `rst`=1 at an edge):
  - pointers 0, `fill_level` 0, `m_axis_tvalid` 0
  - `ovf` 0, `pkt_cnt` 0, `drop_cnt` 0, FSM IDLE
  - `m_axis_tdata` and `m_axis_tlast` are don't-care while tvalid=0
- **Latency:** a word written at edge N is visible with `m_axis_tvalid`=1 after edge N (first-word fall-through). Minimum input-to-handshake is one cycle.
- **Throughput:** one word per cycle in and out simultaneously with no bubbles.
- **Reset mid-packet:** FIFO contents are lost and tvalid drops the cycle after reset. The DMA must be re-armed by software.
- **Counters:** saturate at 16'hFFFF.

## Configuration
- `WORD32_AXIS_TX_STATUS_CNT_EN`:
  - **Defined:** `pkt_cnt` and `drop_cnt` are implemented as described.
  - **Undefined:** both ports are tied to 0 and their registers are omitted. `ovf` and `fill_level` remain present in both builds.

## Test plan
- **Basic packet:** reset, tready=1, 16 words 0x00010203.. with last on word 16 → 16 handshakes in order, tlast only on the 16th, `pkt_cnt`=1, `fill_level` never exceeds 1.
- **Backpressure fill:** tready=0, write 16 words (`DEPTH`=16) → `fill_level`=16, no `ovf`. Then tready=1 → 16 words out in order, `fill_level` returns to 0.
- **Overflow:** tready=0, write 18 words → words 17–18 dropped, `ovf`=1, `drop_cnt`=2. Drain yields exactly words 1–16. Pulse `ovf_clr` → `ovf`=0.
- **Full plus simultaneous read:** fill to 16, then assert tready and in_valid together for one cycle → read succeeds, write dropped, `fill_level`=15, `drop_cnt` +1.
- **Wrap and stall pattern:** 100 words with tready toggled pseudo-randomly, with the in_valid rate kept low enough not to overflow → output matches input order across multiple pointer wraps, and tdata/tlast stay stable while tvalid=1 and tready=0.
- **Reset mid-packet:** 5 words queued, tready=0, assert rst one cycle → `fill_level`=0, `m_axis_tvalid`=0, counters and `ovf` are 0.
